csa_resolve_adder: RTL and testbench

- Downstream consumer of the final carry-save compression stage in the mantissa multiplier.
- Takes the redundant sum/carry vector pair and resolves it to a single binary value with a multi-cycle chunked carry-propagate adder.
- Uses ready/valid handshakes on both sides so the multiplier pipeline can stall.
- Feeds the normalise/round stage.

---
 rtl/csa_resolve_adder.sv | 134 +++++++++++++
 tb/tb_csa_resolve_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_adder.sv
// csa_resolve_adder: resolves a CSA sum/carry pair over NCHUNK cycles.
// Define CSA_RESOLVE_STICKY_EN to add the sticky output (STICKY_BITS).
module csa_resolve_adder #(
  parameter int WIDTH = 38,
  parameter int CHUNK = 8
`ifdef CSA_RESOLVE_STICKY_EN
  ,
  parameter int STICKY_BITS = 14
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef CSA_RESOLVE_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LB = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] ins, mask;
  logic [IW-1:0]    idx;
  logic             carry_q, cout_q;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum_ch;
  logic [31:0]      shamt;
  logic             accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (idx == LAST);
  assign shamt  = 32'(idx) * 32'(CHUNK);

  // Chunks are zero-extended past WIDTH by the shift and cast.
  always_comb begin
    a_ch   = CHUNK'(a_q >> shamt);
    b_ch   = CHUNK'(b_q >> shamt);
    sum_ch = {1'b0, a_ch} + {1'b0, b_ch}
           + (CHUNK + 1)'(carry_q);
    ins    = WIDTH'(sum_ch[CHUNK-1:0]) << shamt;
    mask   = ~(WIDTH'({CHUNK{1'b1}}) << shamt);
    res_d  = (res_q & mask) | ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (in_valid)  state_d = ADD;
      ADD:  if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_q     <= sum_in;
          b_q     <= carry_in;
          res_q   <= '0;
          idx     <= '0;
          carry_q <= 1'b0;
          cout_q  <= 1'b0;
        end
        (state == ADD): begin
          res_q   <= res_d;
          carry_q <= sum_ch[CHUNK];
          idx     <= last ? '0 : idx + 1'b1;
          // Carry out of bit WIDTH-1, not of the padded chunk.
          if (last) cout_q <= sum_ch[LB];
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
  assign cout   = cout_q;

`ifdef CSA_RESOLVE_STICKY_EN
  localparam logic [WIDTH-1:0] SMASK =
    (STICKY_BITS >= WIDTH) ? {WIDTH{1'b1}}
                           : ({WIDTH{1'b1}} >> (WIDTH - STICKY_BITS));

  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sticky_q <= 1'b0;
    else if (accept)         sticky_q <= 1'b0;
    else if (state == ADD)   sticky_q <= sticky_q | (|(ins & SMASK));
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb_csa_resolve_adder: scoreboard bench for csa_resolve_adder.
// Sticky checks are active when CSA_RESOLVE_STICKY_EN is defined.
module tb_csa_resolve_adder;

  localparam int W   = 38;
  localparam int NCH = 5;
  localparam int SB  = 14;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_in = '0;
  logic [W-1:0] carry_in = '0;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] result;
`ifdef CSA_RESOLVE_STICKY_EN
  logic         sticky;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   done_cyc[$];
  exp_t mon_e;

  csa_resolve_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_in   (sum_in),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout)
`ifdef CSA_RESOLVE_STICKY_EN
    ,
    .sticky   (sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic [W:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b};
    e.res = s[W-1:0];
    e.co  = s[W];
    e.st  = |s[SB-1:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_result", 64'(result), 64'(mon_e.res));
        check("sb_cout", 64'(cout), 64'(mon_e.co));
`ifdef CSA_RESOLVE_STICKY_EN
        check("sb_sticky", 64'(sticky), 64'(mon_e.st));
`endif
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    sum_in   = a;
    carry_in = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(sb.size() == 0 && !out_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic add, one-cycle pulse with out_ready high
    out_ready = 1'b1;
    send(38'h00_0001_2345, 38'h00_0001_0000);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency", 64'(n), 64'(NCH));
    check("basic_result", 64'(result), 64'h00_0002_2345);
    check("basic_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    check("pulse_width", 64'(out_valid), 64'd0);
    check("ready_after", 64'(in_ready), 64'd1);

    // full ripple across every chunk
    send(38'h3F_FFFF_FFFF, 38'h00_0000_0001);
    in_valid = 1'b0;
    wait_valid(n);
    check("ripple_result", 64'(result), 64'd0);
    check("ripple_cout", 64'(cout), 64'd1);
    drain();

    // backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    ra = 38'h12_3456_789A;
    rb = 38'h0F_0F0F_0F0E;
    e = model(ra, rb);
    send(ra, rb);
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      sum_in   = W'($urandom);
      carry_in = W'($urandom);
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", 64'(result), 64'(e.res));
      check("bp_cout", 64'(cout), 64'(e.co));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("idle_retain", 64'(result), 64'(e.res));
    drain();

    // asynchronous reset mid-operation
    send(38'h01_1111_1111, 38'h02_2222_2222);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_result", 64'(result), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(38'h5, 38'h3);
    in_valid = 1'b0;
    drain();
    check("post_rst_result", 64'(result), 64'h8);

    // back-to-back with in_valid held high
    done_cyc.delete();
    send(38'h00_1234_5678, 38'h00_0FED_CBA8);
    send(38'h2A_AAAA_AAAA, 38'h15_5555_5556);
    send(38'h3F_0000_00FF, 38'h01_0000_0F02);
    in_valid = 1'b0;
    drain();
    check("b2b_count", 64'(done_cyc.size()), 64'd3);
    for (int i = 1; i < done_cyc.size(); i++)
      check("b2b_gap", 64'(done_cyc[i] - done_cyc[i-1]), 64'(NCH + 2));

    // random pairs with random downstream stall
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'b0;
      ra = {W'($urandom), W'($urandom)} >> 0;
      rb = W'({$urandom, $urandom});
      ra = W'({$urandom, $urandom});
      send(ra, rb);
      in_valid = 1'b0;
      repeat ($urandom_range(5, 12)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
    end

`ifdef CSA_RESOLVE_STICKY_EN
    out_ready = 1'b0;
    send(38'h0000_4000, 38'h0);
    in_valid = 1'b0;
    wait_valid(n);
    check("sticky_clear", 64'(sticky), 64'd0);
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    send(38'h0000_2000, 38'h0);
    in_valid = 1'b0;
    wait_valid(n);
    check("sticky_set", 64'(sticky), 64'd1);
    out_ready = 1'b1;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
